// File: rtl/modbus_rtu_master.sv
`default_nettype none
// ============================================================================
//  Module      : modbus_rtu_master
//  Description : Wishbone slave that turns single-register bus cycles into
//                Modbus RTU master transactions (FC03 read, FC06 write) over
//                a byte-level UART transmit handshake and receive strobe.
//                Optional build macro MODBUS_MASTER_RETRY_EN re-sends the
//                request up to RETRIES extra times after a timeout or a
//                CRC/format failure.
//  Revision    : 1.0 - initial release
// ============================================================================
module modbus_rtu_master #(
    parameter logic [23:0] RESP_TIMEOUT = 24'd100000,
    parameter logic [23:0] TURNAROUND   = 24'd2000,
    parameter int unsigned RETRIES      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] wbAdrI,
    input  logic [15:0] wbDatI,
    output logic [15:0] wbDatO,
    input  logic        wbCycI,
    input  logic        wbStbI,
    input  logic        wbWeI,
    output logic        wbAckO,
    output logic        wbErrO,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    input  logic        rxSilence,
    output logic        busy
);

`ifdef MODBUS_MASTER_RETRY_EN
    localparam logic c_RETRY_EN = 1'b1;
`else
    localparam logic c_RETRY_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_BUILD = 4'd1,
        S_TX    = 4'd2,
        S_TURN  = 4'd3,
        S_WAIT  = 4'd4,
        S_RX    = 4'd5,
        S_CHECK = 4'd6,
        S_DONE  = 4'd7,
        S_FAIL  = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_adr;
    logic [15:0] r_dat;
    logic        r_we;
    logic [2:0]  r_idx;
    logic [15:0] r_crc;
    logic [23:0] r_cnt;
    logic [7:0]  r_buf [8];
    logic [3:0]  r_len;
    logic        r_ovr;
    logic [7:0]  r_retry;

    logic [7:0]  w_txByte;
    logic [7:0]  w_fc;
    logic        w_bcast;
    logic        w_timeout;
    logic        w_rxTake;
    logic        w_frameOk;
    logic        w_rdOk;
    logic        w_wrOk;
    logic        w_exc;
    logic        w_canRetry;

    // Modbus CRC-16, reflected polynomial 0xA001, one byte per call
    function automatic logic [15:0] crcByte(input logic [15:0] crcIn, input logic [7:0] dataIn);
        logic [15:0] c;
        c = crcIn ^ {8'h00, dataIn};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign w_fc       = r_we ? 8'h06 : 8'h03;
    assign w_bcast    = (r_adr[23:16] == 8'h00);
    assign w_timeout  = (r_cnt == RESP_TIMEOUT - 24'd1);
    assign w_rxTake   = rxValid && ((r_state == S_WAIT) || (r_state == S_RX));
    assign w_canRetry = c_RETRY_EN && (32'(r_retry) < RETRIES);

    // Response qualification; only meaningful while in CHECK
    assign w_frameOk = (r_crc == 16'h0000) && !r_ovr && (r_buf[0] == r_adr[23:16]);
    assign w_rdOk    = w_frameOk && !r_we && (r_len == 4'd7) &&
                       (r_buf[1] == 8'h03) && (r_buf[2] == 8'h02);
    assign w_wrOk    = w_frameOk && r_we && (r_len == 4'd8) && (r_buf[1] == 8'h06) &&
                       (r_buf[2] == r_adr[15:8]) && (r_buf[3] == r_adr[7:0]) &&
                       (r_buf[4] == r_dat[15:8]) && (r_buf[5] == r_dat[7:0]);
    assign w_exc     = w_frameOk && (r_len == 4'd5) && (r_buf[1] == {1'b1, w_fc[6:0]});

    // Request byte selected by the transmit index; bytes 6/7 are the running CRC
    always_comb begin
        w_txByte = 8'h00;
        case (r_idx)
            3'd0:    w_txByte = r_adr[23:16];
            3'd1:    w_txByte = w_fc;
            3'd2:    w_txByte = r_adr[15:8];
            3'd3:    w_txByte = r_adr[7:0];
            3'd4:    w_txByte = r_we ? r_dat[15:8] : 8'h00;
            3'd5:    w_txByte = r_we ? r_dat[7:0]  : 8'h01;
            3'd6:    w_txByte = r_crc[7:0];
            default: w_txByte = r_crc[15:8];
        endcase
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next  = r_state;
        txValid = 1'b0;
        txData  = 8'h00;
        wbAckO  = 1'b0;
        wbErrO  = 1'b0;
        busy    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (wbCycI && wbStbI) w_next = S_BUILD;
            S_BUILD: w_next = (!r_we && w_bcast) ? S_FAIL : S_TX;
            S_TX: begin
                txValid = 1'b1;
                txData  = w_txByte;
                if (txReady && (r_idx == 3'd7)) w_next = (r_we && w_bcast) ? S_TURN : S_WAIT;
            end
            S_TURN:  if (r_cnt == TURNAROUND - 24'd1) w_next = S_DONE;
            S_WAIT: begin
                if (rxValid)        w_next = S_RX;
                else if (w_timeout) w_next = w_canRetry ? S_BUILD : S_FAIL;
            end
            S_RX:    if (rxSilence && ((r_len != 4'd0) || rxValid)) w_next = S_CHECK;
            S_CHECK: begin
                if (w_rdOk || w_wrOk) w_next = S_DONE;
                else if (w_exc)       w_next = S_FAIL;
                else                  w_next = w_canRetry ? S_BUILD : S_FAIL;
            end
            S_DONE: begin
                wbAckO = wbCycI;
                w_next = S_IDLE;
            end
            S_FAIL: begin
                wbErrO = wbCycI;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, request latch, CRC, counters and response buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            wbDatO  <= 16'h0000;
            r_adr   <= 24'h000000;
            r_dat   <= 16'h0000;
            r_we    <= 1'b0;
            r_idx   <= 3'd0;
            r_crc   <= 16'h0000;
            r_cnt   <= 24'd0;
            r_len   <= 4'd0;
            r_ovr   <= 1'b0;
            r_retry <= 8'd0;
            for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (wbCycI && wbStbI) begin
                        r_adr   <= wbAdrI;
                        r_dat   <= wbDatI;
                        r_we    <= wbWeI;
                        r_retry <= 8'd0;
                    end
                end
                S_BUILD: begin
                    r_crc <= 16'hFFFF;
                    r_idx <= 3'd0;
                    r_cnt <= 24'd0;
                    r_len <= 4'd0;
                    r_ovr <= 1'b0;
                end
                S_TX: begin
                    if (txReady) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx < 3'd6) r_crc <= crcByte(r_crc, w_txByte);
                        if (r_idx == 3'd7) begin
                            // Re-seed for the response and start the wait/turnaround count
                            r_crc <= 16'hFFFF;
                            r_cnt <= 24'd0;
                        end
                    end
                end
                S_TURN: r_cnt <= r_cnt + 24'd1;
                S_WAIT: begin
                    r_cnt <= r_cnt + 24'd1;
                    if (!rxValid && w_timeout && w_canRetry) r_retry <= r_retry + 8'd1;
                end
                S_CHECK: begin
                    if (w_rdOk) begin
                        wbDatO <= {r_buf[3], r_buf[4]};
                    end else if (!w_wrOk && w_exc) begin
                        wbDatO <= {8'h00, r_buf[2]};
                    end else if (!w_wrOk && w_canRetry) begin
                        r_retry <= r_retry + 8'd1;
                    end
                end
                default: ;
            endcase
            // Received bytes: CRC over all of them, keep the first eight
            if (w_rxTake) begin
                r_crc <= crcByte(r_crc, rxData);
                if (r_len < 4'd8) begin
                    r_buf[r_len[2:0]] <= rxData;
                    r_len             <= r_len + 4'd1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modbus_rtu_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modbus_rtu_master
//  Description : Self-checking bench for modbus_rtu_master: table of request /
//                response vectors plus directed multi-cycle corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modbus_rtu_master;

    localparam logic [23:0] TO    = 24'd200;
    localparam logic [23:0] TA    = 24'd30;
    localparam int          LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] wbAdrI = '0;
    logic [15:0] wbDatI = '0;
    logic [15:0] wbDatO;
    logic        wbCycI = 1'b0;
    logic        wbStbI = 1'b0;
    logic        wbWeI = 1'b0;
    logic        wbAckO;
    logic        wbErrO;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady = 1'b1;
    logic [7:0]  rxData = '0;
    logic        rxValid = 1'b0;
    logic        rxSilence = 1'b0;
    logic        busy;

    modbus_rtu_master #(.RESP_TIMEOUT(TO), .TURNAROUND(TA), .RETRIES(2)) dut (
        .clk(clk), .rst(rst),
        .wbAdrI(wbAdrI), .wbDatI(wbDatI), .wbDatO(wbDatO),
        .wbCycI(wbCycI), .wbStbI(wbStbI), .wbWeI(wbWeI),
        .wbAckO(wbAckO), .wbErrO(wbErrO),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .rxSilence(rxSilence),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [23:0] adr;
        logic [15:0] dat;
        logic [63:0] tx;       // expected request, first byte in MSBs
        bit          txCrc;    // replace tx bytes 6/7 by the reference CRC
        logic [95:0] rsp;      // response bytes, first byte in MSBs
        int          rspN;
        bit          rspCrc;   // append reference CRC to the response
        bit          flip;     // invert the last response byte
        bit          expAck;
        logic [15:0] expDat;
    } vec_t;

    int total = 0;
    int bad = 0;
    int stallBad = 0;
    logic [7:0] rspBytes [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chkRange(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Reference Modbus CRC, bit-serial over an MSB-first byte string
    function automatic logic [15:0] refCrc(input logic [95:0] msg, input int n);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = msg[95-8*i -: 8];
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    function automatic vec_t mk(input string nm, input logic we, input logic [23:0] adr,
                                input logic [15:0] dat, input logic [63:0] tx, input bit txCrc,
                                input logic [95:0] rsp, input int rspN, input bit rspCrc,
                                input bit flip, input bit expAck, input logic [15:0] expDat);
        vec_t v;
        v.name = nm; v.we = we; v.adr = adr; v.dat = dat; v.tx = tx; v.txCrc = txCrc;
        v.rsp = rsp; v.rspN = rspN; v.rspCrc = rspCrc; v.flip = flip;
        v.expAck = expAck; v.expDat = expDat;
        return v;
    endfunction

    function automatic logic [63:0] expFrame(input logic [63:0] tx, input bit txCrc);
        logic [15:0] c;
        if (!txCrc) return tx;
        c = refCrc({tx, 32'h0}, 6);
        return {tx[63:16], c[7:0], c[15:8]};
    endfunction

    task automatic loadRsp(input logic [95:0] m, input int n, input bit addCrc, input bit flip,
                           output int nb);
        logic [15:0] c;
        nb = n;
        for (int i = 0; i < n; i++) rspBytes[i] = m[95-8*i -: 8];
        if (addCrc) begin
            c = refCrc(m, n);
            rspBytes[nb]   = c[7:0];
            rspBytes[nb+1] = c[15:8];
            nb += 2;
        end
        if (flip) rspBytes[nb-1] = ~rspBytes[nb-1];
    endtask

    task automatic startCycle(input logic we, input logic [23:0] adr, input logic [15:0] dat);
        @(negedge clk);
        wbWeI = we; wbAdrI = adr; wbDatI = dat;
        wbCycI = 1'b1; wbStbI = 1'b1;
    endtask

    // Collect request bytes; optionally stall txReady for 50 clocks before byte stallAt
    task automatic doTx(input int nMax, input int stallAt, output logic [63:0] got, output int n);
        int       guard;
        bit       stalled;
        logic [7:0] held;
        got = '0; n = 0; guard = 0; stalled = 0;
        while (n < nMax && guard < LIMIT) begin
            @(negedge clk);
            guard++;
            if (n == stallAt && !stalled && txValid) begin
                txReady = 1'b0;
                held    = txData;
                stalled = 1;
                for (int s = 0; s < 50; s++) begin
                    @(negedge clk);
                    if (txData !== held || txValid !== 1'b1) stallBad++;
                end
                txReady = 1'b1;
            end
            if (txValid && txReady) begin
                got[63-8*n -: 8] = txData;
                n++;
            end
        end
    endtask

    task automatic sendResp(input int nb);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            rxData = rspBytes[i]; rxValid = 1'b1;
            @(negedge clk);
            rxValid = 1'b0;
        end
        rxSilence = 1'b1;
    endtask

    // Wait for ack/err, check it lasts one clock, then close the bus cycle
    task automatic waitResult(output bit ack, output bit err, output int k, output bit sawTx);
        ack = 0; err = 0; k = 0; sawTx = 0;
        while (!ack && !err && k < LIMIT) begin
            @(negedge clk);
            k++;
            ack = wbAckO; err = wbErrO;
            if (txValid) sawTx = 1;
        end
        chk("resultSeen", 64'(ack | err), 64'd1);
        if (ack || err) begin
            @(negedge clk);
            chk("pulseWidth", 64'({wbAckO, wbErrO}), 64'd0);
        end
        wbCycI = 1'b0; wbStbI = 1'b0; rxSilence = 1'b0;
    endtask

    task automatic runVec(input vec_t v);
        logic [63:0] got;
        int n, nb, k;
        bit ack, err, sawTx;
        loadRsp(v.rsp, v.rspN, v.rspCrc, v.flip, nb);
        startCycle(v.we, v.adr, v.dat);
        doTx(8, -1, got, n);
        chk({v.name, ".tx"}, got, expFrame(v.tx, v.txCrc));
        sendResp(nb);
        waitResult(ack, err, k, sawTx);
        chk({v.name, ".result"}, 64'({ack, err}), v.expAck ? 64'd2 : 64'd1);
        chk({v.name, ".dat"}, 64'(wbDatO), 64'(v.expDat));
        chk({v.name, ".busy"}, 64'(busy), 64'd0);
    endtask

    vec_t tbl [10];

    initial begin
        logic [63:0] got;
        int n, nb, k, seen;
        bit ack, err, sawTx;

        tbl[0] = mk("rd01", 0, 24'h010000, 16'h0000, 64'h010300000001840A, 0,
                    {40'h0103021234, 56'h0}, 5, 1, 0, 1, 16'h1234);
        tbl[1] = mk("wr01", 1, 24'h010001, 16'h0003, 64'h010600010003980B, 0,
                    {64'h010600010003980B, 32'h0}, 8, 0, 0, 1, 16'h1234);
        tbl[2] = mk("rd11", 0, 24'h11006B, 16'h0000, {48'h1103006B0001, 16'h0}, 1,
                    {40'h110302ABCD, 56'h0}, 5, 1, 0, 1, 16'hABCD);
        tbl[3] = mk("crcBad", 0, 24'h010000, 16'h0000, 64'h010300000001840A, 0,
                    {40'h0103021234, 56'h0}, 5, 1, 1, 0, 16'hABCD);
        tbl[4] = mk("exc", 0, 24'h010000, 16'h0000, 64'h010300000001840A, 0,
                    {24'h018302, 72'h0}, 3, 1, 0, 0, 16'h0002);
        tbl[5] = mk("wrongSlave", 0, 24'h010000, 16'h0000, 64'h010300000001840A, 0,
                    {40'h0203021234, 56'h0}, 5, 1, 0, 0, 16'h0002);
        tbl[6] = mk("badEcho", 1, 24'h010001, 16'h0003, 64'h010600010003980B, 0,
                    {48'h010600010004, 48'h0}, 6, 1, 0, 0, 16'h0002);
        tbl[7] = mk("shortRd", 0, 24'h010000, 16'h0000, 64'h010300000001840A, 0,
                    {32'h01030212, 64'h0}, 4, 1, 0, 0, 16'h0002);
        tbl[8] = mk("wr0A", 1, 24'h0A1234, 16'hBEEF, {48'h0A061234BEEF, 16'h0}, 1,
                    {48'h0A061234BEEF, 48'h0}, 6, 1, 0, 1, 16'h0002);
        tbl[9] = mk("overrun", 1, 24'h010001, 16'h0003, 64'h010600010003980B, 0,
                    {72'h010600010003980B00, 24'h0}, 9, 0, 0, 0, 16'h0002);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset", 64'({wbAckO, wbErrO, txValid, busy, txData, wbDatO}), 64'd0);
        rst = 1'b1;

        // Stray bytes in IDLE are ignored
        @(negedge clk);
        rxData = 8'h55; rxValid = 1'b1; rxSilence = 1'b1;
        repeat (3) @(negedge clk);
        rxValid = 1'b0; rxSilence = 1'b0;
        chk("strayIdle", 64'({busy, txValid}), 64'd0);

        for (int i = 0; i < 10; i++) runVec(tbl[i]);

        // No response: error after the response timeout
        startCycle(0, 24'h010000, 16'h0000);
        doTx(8, -1, got, n);
        chk("timeout.tx", got, 64'h010300000001840A);
        waitResult(ack, err, k, sawTx);
        chk("timeout.result", 64'({ack, err}), 64'd1);
        chkRange("timeout.clocks", k - 1, int'(TO) - 1, int'(TO) + 1);
        chk("timeout.dat", 64'(wbDatO), 64'h0002);

        // Broadcast write: no wait for a response, ack after the turnaround
        startCycle(1, 24'h000001, 16'h0003);
        doTx(8, -1, got, n);
        chk("bcastWr.tx", got, expFrame({48'h000600010003, 16'h0}, 1));
        waitResult(ack, err, k, sawTx);
        chk("bcastWr.result", 64'({ack, err}), 64'd2);
        chkRange("bcastWr.clocks", k - 1, int'(TA) - 1, int'(TA) + 1);

        // Broadcast read: illegal, immediate error and nothing sent
        startCycle(0, 24'h000005, 16'h0000);
        waitResult(ack, err, k, sawTx);
        chk("bcastRd.result", 64'({ack, err}), 64'd1);
        chk("bcastRd.noTx", 64'(sawTx), 64'd0);
        chkRange("bcastRd.clocks", k, 1, 3);

        // Transmitter stall mid-frame
        stallBad = 0;
        startCycle(0, 24'h010000, 16'h0000);
        doTx(8, 3, got, n);
        chk("stall.tx", got, 64'h010300000001840A);
        chk("stall.stable", 64'(stallBad), 64'd0);
        loadRsp({40'h0103025678, 56'h0}, 5, 1, 0, nb);
        sendResp(nb);
        waitResult(ack, err, k, sawTx);
        chk("stall.result", 64'({ack, err}), 64'd2);
        chk("stall.dat", 64'(wbDatO), 64'h5678);

        // Cycle dropped before completion: no pulse, back to idle
        startCycle(0, 24'h010000, 16'h0000);
        doTx(8, -1, got, n);
        wbCycI = 1'b0; wbStbI = 1'b0;
        loadRsp({40'h0103029999, 56'h0}, 5, 1, 0, nb);
        sendResp(nb);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbAckO || wbErrO) seen++;
        end
        rxSilence = 1'b0;
        chk("abort.noPulse", 64'(seen), 64'd0);
        chk("abort.busy", 64'(busy), 64'd0);

        // Reset in the middle of the request
        startCycle(0, 24'h010000, 16'h0000);
        doTx(3, -1, got, n);
        rst = 1'b0;
        @(negedge clk);
        chk("rstTx.txValid", 64'(txValid), 64'd0);
        chk("rstTx.busy", 64'(busy), 64'd0);
        wbCycI = 1'b0; wbStbI = 1'b0;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbAckO || wbErrO || txValid) seen++;
        end
        chk("rstTx.quiet", 64'(seen), 64'd0);

        // Normal operation after the reset
        runVec(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
